// File: rtl/fma16.sv
// Half-precision fused multiply-add: exact fixed-point sum of (+/-x*y) and (+/-z), one rounding step.
// Combinational result/flags plus a registered copy for pipelined users.
module fma16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [15:0] result_q,
  output logic [3:0]  flags_q
);

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [1:0]  RZ = 2'b00, RNE = 2'b01, RM = 2'b10, RP = 2'b11;

  function automatic logic [10:0] sig_of(input logic [14:0] v);
    return {v[14:10] != 5'd0, v[9:0]};
  endfunction

  function automatic logic [4:0] exp_of(input logic [14:0] v);
    return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
  endfunction

  function automatic logic is_inf(input logic [14:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
  endfunction

  function automatic logic is_nan(input logic [14:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  // Unused operands are replaced by neutral values so the rest of the datapath is uniform.
  logic [15:0] ye, ze;
  assign ye = mul ? y : 16'h3C00;
  assign ze = add ? z : 16'h0000;

  logic sp, sa;
  assign sp = x[15] ^ ye[15] ^ negp;
  assign sa = ze[15] ^ (add & negz);

  logic nan_any, snan_any, x_inf, y_inf, z_inf, x_zero, y_zero;
  assign nan_any  = is_nan(x[14:0]) | is_nan(ye[14:0]) | is_nan(ze[14:0]);
  assign snan_any = (is_nan(x[14:0]) & ~x[9]) | (is_nan(ye[14:0]) & ~ye[9]) |
                    (is_nan(ze[14:0]) & ~ze[9]);
  assign x_inf  = is_inf(x[14:0]);
  assign y_inf  = is_inf(ye[14:0]);
  assign z_inf  = is_inf(ze[14:0]);
  assign x_zero = (x[14:0] == 15'd0);
  assign y_zero = (ye[14:0] == 15'd0);

  logic p_inf, invalid;
  assign p_inf   = x_inf | y_inf;
  assign invalid = (x_inf & y_zero) | (y_inf & x_zero) | (p_inf & z_inf & (sp != sa));

  // Both terms scaled by 2^48 so the smallest product (2^-48) is integer bit 0.
  logic [21:0] pm;
  logic [5:0]  pe;
  logic [80:0] pfix, afix;
  assign pm   = {11'd0, sig_of(x[14:0])} * {11'd0, sig_of(ye[14:0])};
  assign pe   = {1'b0, exp_of(x[14:0])} + {1'b0, exp_of(ye[14:0])};
  assign pfix = {59'd0, pm} << (pe - 6'd2);
  assign afix = {70'd0, sig_of(ze[14:0])} << ({1'b0, exp_of(ze[14:0])} + 6'd23);

  logic [80:0] mag;
  logic        sgn;
  always_comb begin
    mag = '0;
    sgn = sp;
    if (sp == sa) begin
      mag = pfix + afix;
      sgn = sp;
    end else if (pfix >= afix) begin
      mag = pfix - afix;
      sgn = sp;
    end else begin
      mag = afix - pfix;
      sgn = sa;
    end
  end

  logic [6:0] lead;
  always_comb begin
    lead = 7'd0;
    for (int i = 0; i < 81; i++)
      if (mag[i]) lead = 7'(i);
  end

  // Below bit 34 the value is subnormal and the quantum is fixed at 2^-24 (bit 24).
  logic [6:0]  lsb;
  logic [10:0] kept;
  logic        guard, sticky, inc, inexact;
  logic [17:0] enc;
  assign lsb     = (lead >= 7'd34) ? (lead - 7'd10) : 7'd24;
  assign kept    = 11'(mag >> lsb);
  assign guard   = mag[lsb - 7'd1];
  assign sticky  = |(mag << (7'd82 - lsb));
  assign inexact = guard | sticky;

  always_comb begin
    inc = 1'b0;
    case (roundmode)
      RZ:  inc = 1'b0;
      RNE: inc = guard & (sticky | kept[0]);
      RM:  inc = inexact & sgn;
      RP:  inc = inexact & ~sgn;
      default: inc = 1'b0;
    endcase
  end

  // Hidden bit of kept carries into the exponent field, so encoding is a plain add.
  assign enc = {1'b0, lsb - 7'd24, 10'd0} + {7'd0, kept} + {17'd0, inc};

  logic to_max;
  assign to_max = (roundmode == RZ) | ((roundmode == RM) & ~sgn) | ((roundmode == RP) & sgn);

  always_comb begin
    result = 16'h0000;
    flags  = 4'b0000;
    if (nan_any) begin
      result = QNAN;
      flags  = {snan_any, 3'b000};
    end else if (invalid) begin
      result = QNAN;
      flags  = 4'b1000;
    end else if (p_inf) begin
      result = {sp, 15'h7C00};
    end else if (z_inf) begin
      result = {sa, 15'h7C00};
    end else if (mag == 81'd0) begin
      result = {(sp == sa) ? sp : (roundmode == RM), 15'd0};
    end else if (enc > 18'h07BFF) begin
      result = to_max ? {sgn, 15'h7BFF} : {sgn, 15'h7C00};
      flags  = 4'b0101;
    end else begin
      result = {sgn, enc[14:0]};
      flags  = {2'b00, inexact & (enc < 18'h00400), inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 16'h0000;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result;
      flags_q  <= flags;
    end
  end

endmodule

// File: tb/tb_fma16.sv
// Vector bench for fma16: table of operand/expected records, combinational check plus
// scoreboard check of the registered copy one edge later, and a reset sequence.
module tb_fma16;

  logic        clk, reset;
  logic [15:0] x, y, z;
  logic        mul, add, negp, negz;
  logic [1:0]  roundmode;
  logic [15:0] result, result_q;
  logic [3:0]  flags, flags_q;

  fma16 dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .z(z),
    .mul(mul), .add(add), .negp(negp), .negz(negz), .roundmode(roundmode),
    .result(result), .flags(flags), .result_q(result_q), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x, y, z;
    logic        mul, add, negp, negz;
    logic [1:0]  rm;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    int          idx;
    logic [19:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_applied = 0;
  int   n_fail    = 0;

  localparam logic [1:0] RZ = 2'b00, RNE = 2'b01, RM = 2'b10, RP = 2'b11;

  task automatic addv(input logic [15:0] vx, vy, vz, input logic vm, va, vnp, vnz,
                      input logic [1:0] vrm, input logic [15:0] vres, input logic [3:0] vflg);
    vec_t v;
    v.x = vx; v.y = vy; v.z = vz; v.mul = vm; v.add = va; v.negp = vnp; v.negz = vnz;
    v.rm = vrm; v.res = vres; v.flg = vflg;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [19:0] got, input logic [19:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got result/flags %h/%b, expected %h/%b",
               nm, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic drive(input vec_t v);
    x = v.x; y = v.y; z = v.z; mul = v.mul; add = v.add;
    negp = v.negp; negz = v.negz; roundmode = v.rm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //    x        y        z        mul   add   negp  negz  rm   result   flags
    addv(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h4200, 4'b0000);
    addv(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b1, 1'b0, RNE, 16'hBC00, 4'b0000);
    addv(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h4000, 4'b0000);
    addv(16'h4000, 16'h1234, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h4200, 4'b0000);
    addv(16'h3C00, 16'h5555, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b1, RNE, 16'h0000, 4'b0000);
    addv(16'h3C00, 16'h5555, 16'h3C00, 1'b0, 1'b1, 1'b0, 1'b1, RM,  16'h8000, 4'b0000);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7C00, 4'b0101);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RZ,  16'h7BFF, 4'b0101);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'h7BFF, 4'b0101);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h7C00, 4'b0101);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, RM,  16'hFC00, 4'b0101);
    addv(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, RP,  16'hFBFF, 4'b0101);
    addv(16'h7C00, 16'h0000, 16'h3C00, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h7E00, 4'b1000);
    addv(16'h7C00, 16'h3C00, 16'hFC00, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h7E00, 4'b1000);
    addv(16'h7E00, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7E00, 4'b0000);
    addv(16'h7C01, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7E00, 4'b1000);
    addv(16'h7C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h7C00, 4'b0000);
    addv(16'h7C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b1, 1'b0, RNE, 16'hFC00, 4'b0000);
    addv(16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0000, 4'b0011);
    addv(16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RP,  16'h0001, 4'b0011);
    addv(16'h8001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h8000, 4'b0011);
    addv(16'h0002, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0001, 4'b0000);
    addv(16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h0002, 4'b0000);
    addv(16'h03FF, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h03FF, 4'b0000);
    addv(16'h03FF, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h0400, 4'b0000);
    addv(16'h3C00, 16'h3C00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, RP,  16'h3C01, 4'b0001);
    addv(16'h3C00, 16'h3C00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, RZ,  16'h3C00, 4'b0001);
    addv(16'h3C00, 16'h3C00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, RM,  16'h3BFF, 4'b0001);
    addv(16'h3C00, 16'h3C00, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, RNE, 16'h3C00, 4'b0001);
    addv(16'h3C00, 16'h0000, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h3C00, 4'b0001);
    addv(16'h3C01, 16'h0000, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 16'h3C02, 4'b0001);
    addv(16'h8000, 16'h3C00, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h8000, 4'b0000);
    addv(16'h8000, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE, 16'h0000, 4'b0000);
    addv(16'h8000, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RM,  16'h8000, 4'b0000);
    addv(16'h4200, 16'hC200, 16'h4880, 1'b1, 1'b1, 1'b0, 1'b0, RNE, 16'h0000, 4'b0000);

    // Reset sequence on the registered copy.
    reset = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_q", {result_q, flags_q}, 20'h00000);
    check("reset_hold_comb", {result, flags}, {16'h4200, 4'b0000});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("release_q", {result_q, flags_q}, {16'h4200, 4'b0000});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_q", {result_q, flags_q}, 20'h00000);
    check("midreset_comb", {result, flags}, {16'h4200, 4'b0000});
    @(negedge clk);
    reset = 1'b0;

    // Table: combinational check now, registered check from the scoreboard after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      sb_t g;
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d_comb", i), {result, flags}, {vecs[i].res, vecs[i].flg});
      e.idx = i;
      e.exp = {vecs[i].res, vecs[i].flg};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        n_applied++;
        n_fail++;
        $display("FAIL vec%0d_reg: scoreboard empty", i);
      end else begin
        g = sbq.pop_front();
        check($sformatf("vec%0d_reg", g.idx), {result_q, flags_q}, g.exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

endmodule

// File: doc/fma16.md
Name: fma16

Overview:
- IEEE 754 binary16 (half-precision) fused multiply-add: result = (±x·y) + (±z), with a single rounding step.
- Control bits select multiply-only, add-only or full FMA, plus product/addend negation and one of four rounding modes.
- The arithmetic core is combinational.
- A registered copy of result and exception flags is provided for pipelined users.
- Used as the scalar FP datapath block and as a standalone arithmetic unit under vector test.

Parameters:
- None (format fixed: 1 sign, 5 exponent bits (bias 15), 10 fraction bits).

Ports:
- clk  input  1  clock; only the registered outputs use it.
- reset  input  1  synchronous, active-high; clears the registered outputs.
- x  input  16  multiplicand, binary16.
- y  input  16  multiplier, binary16.
- z  input  16  addend, binary16.
- mul  input  1  1: product = x·y; 0: product = x (y treated as +1.0).
- add  input  1  1: addend = z; 0: addend = +0.
- negp  input  1  negate product sign.
- negz  input  1  negate addend sign.
- roundmode  input  2  00 RZ (toward zero), 01 RNE (nearest, ties to even), 10 RM (toward −inf), 11 RP (toward +inf).
- result  output  16  combinational rounded result, same-cycle.
- flags  output  4  combinational {NV invalid, OF overflow, UF underflow, NX inexact}.
- result_q  output  16  result registered on rising clk.
- flags_q  output  4  flags registered on rising clk.

Behaviour:
- Computation: P = (−1)^negp · x · (mul ? y : 1.0); A = add ? (−1)^negz · z : +0.
  - result = round(P + A), exact intermediate, rounded once per roundmode.
  - Minimum internal width: 22-bit product significand plus alignment/guard/sticky; no double rounding.
- result and flags depend only on current inputs: zero latency, no state.
- result_q/flags_q: load result/flags every rising clk edge.
  - When reset=1 at an edge, they load 0x0000 / 4'b0000 instead.
  - Reset mid-operation affects only these registers; combinational outputs are unaffected.
- Subnormal inputs and outputs fully supported; no flush-to-zero.
- NaN handling:
  - Any NaN input gives canonical quiet NaN 0x7E00.
  - NV is set only for a signaling NaN input or an invalid operation.
- Invalid operations (result 0x7E00, NV=1):
  - inf·0 (only when mul=1);
  - +inf + −inf after negation is applied.
- Infinity: an inf operand with a valid operation gives inf of the correct sign, flags 0.
- Overflow: when the rounded magnitude exceeds 0x7BFF, OF=1 and NX=1.
  - RNE: ±inf.
  - RZ: ±0x7BFF.
  - RM: +0x7BFF or −inf.
  - RP: +inf or −0x7BFF.
- Underflow: UF=1 when the result is tiny (below 2^−14) after rounding AND inexact. NX=1 whenever the rounded result ≠ the exact value.
- Zero sign rules:
  - An exact zero sum of opposite-signed operands is +0, except RM gives −0.
  - (−0)+(−0) = −0.
  - A product underflowing to zero keeps the product sign for the addend-zero cases.
- Addend much smaller than product: it contributes only to sticky and must still affect directed rounding and NX.
- The add=0 path must not alter the sign of an exact-zero product (−0 + +0 under add=0 follows the rules above with addend +0).

Test Plan:
- x=3C00, y=4000, z=3C00, mul=1, add=1, negp=0, negz=0, RNE → result 4200 (3.0), flags 0000.
- Same operands with negp=1 → result BC00 (−1.0), flags 0000. With add=0, negp=0 → 4000, flags 0000.
- mul=0, add=1, x=4000, z=3C00, y=anything → 4200. Then x=3C00, z=3C00, negz=1, RNE → 0000; same with RM → 8000.
- x=7BFF, y=4000, mul=1, add=0:
  - RNE → 7C00, flags OF|NX = 0101.
  - RZ → 7BFF, flags 0101.
  - RM → 7BFF.
- x=7C00, y=0000, mul=1 → 7E00, flags 1000. x=7C00, z=FC00, mul=0, add=1 → 7E00, NV. x=7E00 (quiet NaN), any others → 7E00, flags 0000.
- Registered path:
  - Hold reset=1 for 2 edges → result_q=0000, flags_q=0.
  - Release reset, apply vector 3C00·4000+3C00 RNE → result_q=4200 on the next rising edge.
  - Assert reset for one edge → result_q=0000 while result still shows 4200.
